// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and error encodings for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    localparam int         ERR_OVF     = 0;
    localparam int         ERR_DIV0    = 1;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic is_divmod(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// Bit-serial unsigned multiplier / restoring divider sharing one hi:lo shift pair.
// Outputs are the post-step values so the caller can register the final answer on the last step.
module iter_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   sum, rsh, diff;
    logic             ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    // hi stays below the divisor, so rsh - b never reaches 2^WIDTH and bit WIDTH is the borrow.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rsh  = {hi_q, lo_q[WIDTH-1]};
        diff = rsh - {1'b0, b_q};
        ge   = ~diff[WIDTH];
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = a_mag;
            b_d   = b_mag;
            cnt_d = CW'(WIDTH);
            div_d = is_div;
        end else if (step && cnt_q != '0) begin
            if (div_q) begin
                hi_d = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign product   = {hi_d, lo_d};
    assign quotient  = lo_d;
    assign remainder = hi_d;
    assign last      = step && (cnt_q == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// Clocked signed ALU: single-cycle add/sub, iterative mul/div/mod behind start/busy/done.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op_code,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         err_code
);

    localparam int RW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [RW-1:0]    result_q, result_d;
    logic [1:0]       err_q, err_d;

    logic             accept, load, step, last;
    logic             a_neg, b_neg, b_zero, iter_op;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
    logic [RW-1:0]    prod, mag_final;
    logic [WIDTH:0]   a_ext, b_ext, addsub;

    assign a_neg   = operand_a[WIDTH-1];
    assign b_neg   = operand_b[WIDTH-1];
    assign a_mag   = a_neg ? -operand_a : operand_a;
    assign b_mag   = b_neg ? -operand_b : operand_b;
    assign b_zero  = (operand_b == '0);
    assign iter_op = (op_code == OP_MUL) || (is_divmod(op_code) && !b_zero);
    assign a_ext   = {a_neg, operand_a};
    assign b_ext   = {b_neg, operand_b};
    assign addsub  = (op_code == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

    iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .is_div    (is_divmod(op_code)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .product   (prod),
        .quotient  (quot),
        .remainder (rem),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FINISH behaves like IDLE for acceptance so a start in the done cycle is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ITER:    if (last) state_d = FINISH;
            default: state_d = accept ? (load ? ITER : FINISH) : IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ITER);
        done   = (state_q == FINISH);
        accept = start && (state_q != ITER);
        load   = accept && iter_op;
        step   = (state_q == ITER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        op_d      = op_q;
        neg_d     = neg_q;
        result_d  = result_q;
        err_d     = err_q;
        mag_final = '0;
        if (accept) begin
            op_d  = op_code;
            neg_d = (op_code == OP_MOD) ? a_neg : (a_neg ^ b_neg);
        end
        if (accept && !load) begin
            case (op_code)
                OP_ADD, OP_SUB: begin
                    result_d        = {{(RW-WIDTH-1){addsub[WIDTH]}}, addsub};
                    err_d           = '0;
                    err_d[ERR_OVF]  = addsub[WIDTH] ^ addsub[WIDTH-1];
                end
                OP_DIV, OP_MOD: begin
                    result_d        = '0;
                    err_d           = '0;
                    err_d[ERR_DIV0] = 1'b1;
                end
                default: begin
                    result_d = '0;
                    err_d    = ERR_ILLEGAL;
                end
            endcase
        end
        // Magnitudes are at most 2^(WIDTH-1) per operand, so negation in RW bits is exact.
        if (last) begin
            case (op_q)
                OP_MUL:  mag_final = prod;
                OP_DIV:  mag_final = {{(RW-WIDTH){1'b0}}, quot};
                default: mag_final = {{(RW-WIDTH){1'b0}}, rem};
            endcase
            result_d = neg_q ? -mag_final : mag_final;
            err_d    = '0;
        end
    end

    assign result   = result_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: per-cycle compare against an arithmetic model plus literal checks.
module tb_seq_alu;

    localparam int W = 16;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [3:0]     op_code;
    logic [W-1:0]   operand_a, operand_b;
    logic           busy, done;
    logic [2*W-1:0] result;
    logic [1:0]     err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit checking = 0;

    bit         m_act = 0;
    bit         m_iter = 0;
    int         m_acc = 0;
    longint     m_pend = 0;
    logic [1:0] m_pend_err = '0;
    longint     m_hold = 0;
    logic [1:0] m_hold_err = '0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_code   (op_code),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err_code  (err_code)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    // Reference arithmetic straight from the operation rules.
    function automatic void model(input logic [3:0] op, input logic signed [W-1:0] a,
                                  input logic signed [W-1:0] b, output longint r,
                                  output logic [1:0] e, output bit it);
        longint x, y;
        x = a;
        y = b;
        r = 0;
        e = 2'b00;
        it = 0;
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: begin r = x * y; it = 1; end
            4'd3, 4'd4: begin
                if (y == 0) e = 2'b10;
                else begin
                    r  = (op == 4'd3) ? x / y : x % y;
                    it = 1;
                end
            end
            default: e = 2'b11;
        endcase
        if (op <= 4'd1 && (r > MAXV || r < MINV)) e = 2'b01;
    endfunction

    function automatic bit m_busy();
        return m_act && m_iter && (cyc > m_acc) && (cyc <= m_acc + W);
    endfunction

    function automatic bit m_done();
        return m_act && (cyc == m_acc + (m_iter ? W + 1 : 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit bz;
        if (!rst_n) begin
            m_act      = 0;
            m_hold     = 0;
            m_hold_err = '0;
        end else begin
            bz = m_busy();
            if (m_done()) begin
                m_hold     = m_pend;
                m_hold_err = m_pend_err;
                m_act      = 0;
            end
            if (start && !bz) begin
                model(op_code, operand_a, operand_b, m_pend, m_pend_err, m_iter);
                m_act = 1;
                m_acc = cyc;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] er;
        logic [1:0]  ee;
        if (checking) begin
            er = m_done() ? m_pend[31:0] : m_hold[31:0];
            ee = m_done() ? m_pend_err : m_hold_err;
            chk("cmp_busy", busy, m_busy());
            chk("cmp_done", done, m_done());
            chk("cmp_result", result, er);
            chk("cmp_err", err_code, ee);
        end
    end

    task automatic run_op(input logic [3:0] op, input int a, input int b, input longint er,
                          input logic [1:0] ee, input int elat, input bit now);
        int c0;
        bit seen;
        logic [31:0] e32;
        e32 = er[31:0];
        if (!now) @(negedge clk);
        op_code   = op;
        operand_a = a[W-1:0];
        operand_b = b[W-1:0];
        start     = 1;
        c0        = cyc;
        seen      = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start     = 0;
                op_code   = 4'($urandom);
                operand_a = W'($urandom);
                operand_b = W'($urandom);
            end
            if (done) seen = 1;
        end
        chk("op_done_seen", seen, 1'b1);
        chk("op_latency", cyc - c0, elat);
        chk("op_result", result, e32);
        chk("op_err", err_code, ee);
    endtask

    initial begin
        int c0;
        int ndone;
        bit seen;
        rst_n = 1;
        start = 0;
        op_code = '0;
        operand_a = '0;
        operand_b = '0;
        #1 rst_n = 0;
        checking = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", err_code, 2'b00);
        #2 rst_n = 1;

        run_op(4'd0, 11, 15, 26, 2'b00, 1, 0);
        run_op(4'd1, 11, 15, -4, 2'b00, 1, 0);
        run_op(4'd0, 32000, 16000, 48000, 2'b01, 1, 0);
        run_op(4'd2, 32000, 16000, 512000000, 2'b00, 17, 0);
        run_op(4'd3, -7, 2, -3, 2'b00, 17, 0);
        run_op(4'd4, -7, 2, -1, 2'b00, 17, 0);
        run_op(4'd3, -32768, -1, 32768, 2'b00, 17, 0);
        run_op(4'd3, 11, 0, 0, 2'b10, 1, 0);
        run_op(4'd4, 11, 0, 0, 2'b10, 1, 0);
        run_op(4'd9, 5, 6, 0, 2'b11, 1, 0);
        // back-to-back starts issued in the done cycle
        run_op(4'd1, -32768, 1, -32769, 2'b01, 1, 0);
        run_op(4'd2, -3, 5, -15, 2'b00, 17, 1);
        run_op(4'd4, 7, -2, 1, 2'b00, 17, 1);
        run_op(4'd3, 7, -2, -3, 2'b00, 17, 1);
        run_op(4'd2, -32768, -32768, 1073741824, 2'b00, 17, 0);
        run_op(4'd4, -32768, -1, 0, 2'b00, 17, 0);
        run_op(4'd15, 1, 1, 0, 2'b11, 1, 0);

        // second start while busy must be dropped
        @(negedge clk);
        op_code = 4'd2; operand_a = 16'd3; operand_b = 16'd5; start = 1;
        c0 = cyc;
        seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (k == 3) begin op_code = 4'd0; operand_a = 16'd1; operand_b = 16'd1; start = 1; end
            if (k == 4) start = 0;
            if (done) seen = 1;
        end
        chk("ign_done_seen", seen, 1'b1);
        chk("ign_latency", cyc - c0, 17);
        chk("ign_result", result, 32'd15);
        repeat (3) @(negedge clk);
        chk("ign_no_extra_done", done, 1'b0);
        chk("ign_result_held", result, 32'd15);

        // reset in the middle of a multiply
        @(negedge clk);
        op_code = 4'd2; operand_a = 16'd100; operand_b = 16'd7; start = 1;
        c0 = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < c0 + 8) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        #2 rst_n = 1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        chk("mid_result_zero", result, 32'd0);
        run_op(4'd0, 1, 1, 2, 2'b00, 1, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
